rf_dump_ctrl: RTL and testbench



---
 rtl/mips_dbg_pkg.sv | 20 ++
 rtl/rf_dump_skid.sv | 31 +++
 rtl/rf_dump_ctrl.sv | 120 ++++++++++++
 tb/tb_rf_dump_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared debug-dump constants and FSM state encodings for the MIPS core.
// Also used by the core's RF read-port address mux.
package mips_dbg_pkg;

  localparam int DBG_DATA_W = 32;
  localparam int RF_AW      = 5;
  localparam int IDX_W      = 6;

  localparam logic [IDX_W-1:0] PC_INDEX = 6'd32;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_STALL   = 3'd1;
  localparam state_t S_READ    = 3'd2;
  localparam state_t S_SEND    = 3'd3;
  localparam state_t S_SEND_PC = 3'd4;
  localparam state_t S_DONE    = 3'd5;

endpackage

// File: rtl/rf_dump_skid.sv
// Single-entry output holding register for the dump stream.
// Contents change only on load, so they stay stable under back-pressure.
module rf_dump_skid
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W = DBG_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d_data,
  input  logic [IDX_W-1:0]  d_index,
  input  logic              d_last,
  output logic [DATA_W-1:0] q_data,
  output logic [IDX_W-1:0]  q_index,
  output logic              q_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_data  <= '0;
      q_index <= '0;
      q_last  <= 1'b0;
    end else if (load) begin
      q_data  <= d_data;
      q_index <= d_index;
      q_last  <= d_last;
    end
  end

endmodule

// File: rtl/rf_dump_ctrl.sv
// Debug-dump sequencer: stalls the core and streams RF (and optionally PC).
// Define RF_DUMP_PC_EN to append the PC word (index 32) to the stream.
module rf_dump_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int DATA_W       = DBG_DATA_W,
  parameter int STALL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_req,
  input  logic [DATA_W-1:0] pc_in,
  output logic              cpu_stall,
  output logic              rf_rd_sel,
  output logic [RF_AW-1:0]  rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [RF_AW-1:0] LAST_REG = RF_AW'(NUM_REGS - 1);
  localparam logic [7:0] STALL_END = 8'(STALL_CYCLES - 1);

  state_t            state;
  state_t            state_nx;
  logic              req_q;
  logic [RF_AW-1:0]  idx;
  logic [7:0]        stall_cnt;
  logic              req_edge;
  logic              hs;
  logic              is_last;
  logic              pc_take;
  logic              reg_last;
  logic [DATA_W-1:0] pc_word;
  logic              load;

  assign req_edge = dump_req & ~req_q;
  assign hs       = out_valid & out_ready;
  assign is_last  = (idx == LAST_REG);

`ifdef RF_DUMP_PC_EN
  assign pc_take  = (state == S_SEND) & hs & is_last;
  assign reg_last = 1'b0;
  assign pc_word  = pc_in;
`else
  logic unused_pc;
  assign unused_pc = ^pc_in;
  assign pc_take   = 1'b0;
  assign reg_last  = is_last;
  assign pc_word   = '0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (req_edge) state_nx = S_STALL;
      S_STALL:   if (stall_cnt == STALL_END) state_nx = S_READ;
      S_READ:    state_nx = S_SEND;
      S_SEND: begin
        if (hs) begin
          if (pc_take)      state_nx = S_SEND_PC;
          else if (is_last) state_nx = S_DONE;
          else              state_nx = S_READ;
        end
      end
      S_SEND_PC: if (hs) state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_q     <= 1'b0;
      idx       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      req_q <= dump_req;
      if (state == S_STALL) stall_cnt <= stall_cnt + 8'd1;
      else                  stall_cnt <= '0;
      if (state == S_STALL)
        idx <= '0;
      else if ((state == S_SEND) && hs && !is_last)
        idx <= idx + RF_AW'(1);
    end
  end

  // Register words load in READ; the PC word loads on the last-reg handshake.
  assign load = (state == S_READ) | pc_take;

  rf_dump_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .d_data  (pc_take ? pc_word : rf_rd_data),
    .d_index (pc_take ? PC_INDEX : IDX_W'(idx)),
    .d_last  (pc_take | reg_last),
    .q_data  (out_data),
    .q_index (out_index),
    .q_last  (out_last)
  );

  assign cpu_stall  = (state != S_IDLE);
  assign rf_rd_sel  = (state != S_IDLE);
  assign busy       = (state != S_IDLE);
  assign rf_rd_addr = idx;
  assign out_valid  = (state == S_SEND) | (state == S_SEND_PC);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// Directed bench for rf_dump_ctrl with a tiny RF/PC core model.
// Honours RF_DUMP_PC_EN for the expected stream length.
module tb_rf_dump_ctrl;

`ifdef RF_DUMP_PC_EN
  localparam int NWORDS = 33;
`else
  localparam int NWORDS = 32;
`endif
  localparam int EXP_CYC = 1 + 1 + 2 * 32 + (NWORDS - 32);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dump_req;
  logic [31:0] pc;
  logic        cpu_stall;
  logic        rf_rd_sel;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  logic        rf_init;
  logic        pc_set;
  logic [31:0] pc_set_val;
  logic        running;
  logic [31:0] exp5;
  logic [31:0] exp_pc;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rf_dump_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_req   (dump_req),
    .pc_in      (pc),
    .cpu_stall  (cpu_stall),
    .rf_rd_sel  (rf_rd_sel),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h1000_0000 + i;
    end else if (running && !cpu_stall) begin
      rf[5] <= pc;
    end
    if (pc_set) pc <= pc_set_val;
    else if (running && !cpu_stall) pc <= pc + 32'd4;
  end

  assign rf_rd_data = (rf_rd_addr == 5'd0) ? 32'd0 : rf[rf_rd_addr];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_word(input int i);
    if (i == 32) return exp_pc;
    if (i == 0)  return 32'd0;
    if (i == 5)  return exp5;
    return 32'h1000_0000 + i;
  endfunction

  function automatic logic rdy(input int pat, input int k);
    if (pat == 0) return 1'b1;
    return (k % 4 == 0) || (k % 4 == 3);
  endfunction

  task automatic do_dump(input int pat, input int hold, input bit reedge,
                         input bit abort10, output int words,
                         output int cyc, output int dones,
                         output int stall_low, output bit aborted);
    int ei;
    words = 0; cyc = 0; dones = 0; stall_low = 0; aborted = 0; ei = 0;
    dump_req = 1'b1;
    out_ready = rdy(pat, 0);
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk); #1;
      cyc = k;
      if (k == hold) dump_req = 1'b0;
      if (reedge && k == 20) dump_req = 1'b0;
      if (reedge && k == 21) dump_req = 1'b1;
      out_ready = rdy(pat, k);
      if (!cpu_stall) stall_low++;
      if (done) begin
        dones++;
        break;
      end
      if (out_valid) begin
        if (abort10 && out_index == 6'd10) begin
          aborted = 1'b1;
          break;
        end
        check("word_index", 32'(out_index), 32'(ei));
        check("word_data", out_data, exp_word(ei));
        check("word_last", 32'(out_last), 32'(ei == NWORDS - 1));
        if (out_ready) begin
          words++;
          ei++;
        end
      end
    end
  endtask

  int  words, cyc, dones, stall_low, busy_cnt;
  bit  aborted;

  initial begin
    rst_n = 1'b0; dump_req = 1'b0; out_ready = 1'b0;
    rf_init = 1'b1; pc_set = 1'b1; pc_set_val = 32'h0000_0CD0;
    running = 1'b0; exp5 = 32'h1000_0005; exp_pc = 32'h0000_0CD0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_sel", 32'(rf_rd_sel), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_out", {25'd0, out_last, out_index} | out_data, 32'd0);
    check("rst_addr", 32'(rf_rd_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rf_init = 1'b0; pc_set = 1'b0;
    @(posedge clk); #1;

    // basic dump, ready tied high
    do_dump(0, 2, 1'b0, 1'b0, words, cyc, dones, stall_low, aborted);
    check("t1_words", 32'(words), 32'(NWORDS));
    check("t1_done", 32'(dones), 32'd1);
    check("t1_cycles", 32'(cyc), 32'(EXP_CYC));
    check("t1_stall", 32'(stall_low), 32'd0);
    @(posedge clk); #1;
    check("t1_release", {30'd0, busy, cpu_stall}, 32'd0);
    check("t1_done_pulse", 32'(done), 32'd0);

    // running program frozen at 0x40
    pc_set = 1'b1; pc_set_val = 32'h0000_003C; running = 1'b1;
    @(posedge clk); #1;
    pc_set = 1'b0;
    exp5 = 32'h0000_003C; exp_pc = 32'h0000_0040;
    do_dump(0, 2, 1'b0, 1'b0, words, cyc, dones, stall_low, aborted);
    check("t2_done", 32'(dones), 32'd1);
    check("t2_stall", 32'(stall_low), 32'd0);
    check("t2_pc_at_done", pc, 32'h0000_0040);
    check("t2_rf5", rf[5], 32'h0000_003C);
    @(posedge clk); #1;
    check("t2_unstall", 32'(cpu_stall), 32'd0);
    check("t2_pc_hold", pc, 32'h0000_0040);
    @(posedge clk); #1;
    check("t2_pc_resume", pc, 32'h0000_0044);
    running = 1'b0; rf_init = 1'b1;
    @(posedge clk); #1;
    rf_init = 1'b0; exp5 = 32'h1000_0005; exp_pc = 32'h0000_0044;

    // back-pressure pattern 1-0-0-1
    do_dump(1, 2, 1'b0, 1'b0, words, cyc, dones, stall_low, aborted);
    check("t3_words", 32'(words), 32'(NWORDS));
    check("t3_done", 32'(dones), 32'd1);
    @(posedge clk); #1;

    // async reset during word 10
    do_dump(0, 2, 1'b0, 1'b1, words, cyc, dones, stall_low, aborted);
    check("t4_reached10", 32'(aborted), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t4_async_stall", 32'(cpu_stall), 32'd0);
    check("t4_async_sel", 32'(rf_rd_sel), 32'd0);
    check("t4_async_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t4_idle", 32'(busy), 32'd0);
    do_dump(0, 2, 1'b0, 1'b0, words, cyc, dones, stall_low, aborted);
    check("t4_restart_words", 32'(words), 32'(NWORDS));
    check("t4_restart_done", 32'(dones), 32'd1);
    @(posedge clk); #1;

    // level held high for 200 cycles plus an edge while busy
    do_dump(0, 200, 1'b1, 1'b0, words, cyc, dones, stall_low, aborted);
    check("t5_words", 32'(words), 32'(NWORDS));
    check("t5_done", 32'(dones), 32'd1);
    busy_cnt = 0;
    for (int k = cyc + 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
    end
    dump_req = 1'b0;
    check("t5_no_retrigger", 32'(busy_cnt), 32'd0);
    @(posedge clk); #1;
    do_dump(0, 2, 1'b0, 1'b0, words, cyc, dones, stall_low, aborted);
    check("t5_second_words", 32'(words), 32'(NWORDS));
    check("t5_second_done", 32'(dones), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
